// File: rtl/framer.sv
// Byte-stream framer: wraps each upstream packet in START/STOP delimiters and
// escapes any payload byte that collides with a delimiter or the escape byte.
// The framed stream leaves through a single registered output stage.
//
// Optional feature macro: FRAMER_FRAME_CNT_EN
//   defined   -> frame_count port plus a 16-bit counter of delivered frames
//   undefined -> no frame_count port, no counter logic
//
// Ports
//   aclk, aresetn        clock (rising edge), asynchronous active-low reset
//   frame_count          completed frames, bumped when STOP is accepted (optional)
//   target_tvalid/tready/tdata/tlast   upstream payload bytes (tready is combinational)
//   initiator_tvalid/tready/tdata      downstream framed bytes (registered)
module framer #(
  parameter logic [7:0] START_BYTE  = 8'h7D,
  parameter logic [7:0] STOP_BYTE   = 8'h7E,
  parameter logic [7:0] ESCAPE_BYTE = 8'h7F
) (
  input  logic        aclk,
  input  logic        aresetn,
`ifdef FRAMER_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  input  logic        target_tvalid,
  output logic        target_tready,
  input  logic [7:0]  target_tdata,
  input  logic        target_tlast,
  output logic        initiator_tvalid,
  input  logic        initiator_tready,
  output logic [7:0]  initiator_tdata
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ESC,
    ST_STOP
  } state_e;

  state_e              state_q, state_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                slot_free_c;
  logic                special_c;
  logic                load_c;

  // Output register can take a new byte when empty or being drained this cycle.
  assign slot_free_c = !tvalid_q || initiator_tready;

  assign special_c = (target_tdata == START_BYTE) ||
                     (target_tdata == STOP_BYTE)  ||
                     (target_tdata == ESCAPE_BYTE);

  // State, output stage register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  // Next-state, output-stage load and upstream ready.
  always_comb begin
    state_d       = state_q;
    tdata_d       = tdata_q;
    load_c        = 1'b0;
    target_tready = 1'b0;

    if (slot_free_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (target_tvalid) begin
            load_c  = 1'b1;
            tdata_d = START_BYTE;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (!special_c) begin
            target_tready = 1'b1;
          end
          if (target_tvalid) begin
            load_c = 1'b1;
            if (special_c) begin
              // Escape first; the byte itself stays upstream until ST_ESC.
              tdata_d = ESCAPE_BYTE;
              state_d = ST_ESC;
            end else begin
              tdata_d = target_tdata;
              state_d = target_tlast ? ST_STOP : ST_DATA;
            end
          end
        end
        ST_ESC: begin
          target_tready = 1'b1;
          if (target_tvalid) begin
            load_c  = 1'b1;
            tdata_d = target_tdata;
            state_d = target_tlast ? ST_STOP : ST_DATA;
          end
        end
        ST_STOP: begin
          load_c  = 1'b1;
          tdata_d = STOP_BYTE;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Hold the current byte until accepted; a fresh load always asserts valid.
    tvalid_d = load_c || (tvalid_q && !initiator_tready);
  end

  assign initiator_tvalid = tvalid_q;
  assign initiator_tdata  = tdata_q;

`ifdef FRAMER_FRAME_CNT_EN
  // Marks the held byte as the STOP delimiter, since escaped payload can equal STOP_BYTE.
  logic             is_stop_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      is_stop_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (load_c) begin
        is_stop_q <= (state_q == ST_STOP);
      end
      if (tvalid_q && initiator_tready && is_stop_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign frame_count = cnt_q;
`endif

endmodule

// File: tb/tb_framer.sv
// Directed bench for framer: drives payload frames, collects handshaked output
// bytes with a passive monitor and compares them against hand-written frames.
module tb_framer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        target_tvalid = 1'b0;
  logic [7:0]  target_tdata = 8'h00;
  logic        target_tlast = 1'b0;
  logic        ds_ready = 1'b1;
  logic        toggle_mode = 1'b0;
  logic        target_tready;
  logic        initiator_tvalid;
  logic [7:0]  initiator_tdata;
`ifdef FRAMER_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  framer dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
`ifdef FRAMER_FRAME_CNT_EN
    .frame_count      (frame_count),
`endif
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .target_tlast     (target_tlast),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (ds_ready),
    .initiator_tdata  (initiator_tdata)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  out_q[$];
  int          t_q[$];
  logic [15:0] cnt_q[$];
  int          stall_viol = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  fr_q[$];
  int          base = 0;

  initial forever begin
    @(posedge aclk);
    cyc = cyc + 1;
  end

  // Downstream ready: always high, or alternating every cycle.
  initial forever begin
    @(posedge aclk);
    ds_ready <= toggle_mode ? ~ds_ready : 1'b1;
  end

  // Passive monitor: records accepted beats and watches held data while stalled.
  initial begin : monitor
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (prev_stall && (!initiator_tvalid || initiator_tdata !== prev_data)) begin
          stall_viol = stall_viol + 1;
        end
        if (initiator_tvalid && ds_ready) begin
          out_q.push_back(initiator_tdata);
          t_q.push_back(cyc);
`ifdef FRAMER_FRAME_CNT_EN
          if (initiator_tdata == 8'h7E) cnt_q.push_back(frame_count);
`endif
        end
        prev_stall = initiator_tvalid && !ds_ready;
        prev_data  = initiator_tdata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte from posedge+1 until it is accepted.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int   guard;
    logic acc;
    target_tvalid = 1'b1;
    target_tdata  = d;
    target_tlast  = last;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 200) begin
      @(negedge aclk);
      acc = target_tready;
      @(posedge aclk);
      #1;
      guard = guard + 1;
    end
    chk("byte_accepted", 32'(acc), 32'd1);
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < fr_q.size(); i++) begin
      send_byte(fr_q[i], i == fr_q.size() - 1);
    end
  endtask

  // Compare beats collected since 'base' with exp_q; optionally require no gap cycles.
  task automatic check_out(input string tag, input bit chk_span);
    int         guard;
    int         n;
    logic [7:0] got;
    guard = 0;
    while ((out_q.size() - base) < exp_q.size() && guard < 300) begin
      @(negedge aclk);
      guard = guard + 1;
    end
    repeat (4) @(negedge aclk);
    n = out_q.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < n) ? out_q[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp_q[i]));
    end
    if (chk_span && n == exp_q.size() && n > 0) begin
      chk({tag, "_span"}, 32'(t_q[base + n - 1] - t_q[base]), 32'(n - 1));
    end
  endtask

  task automatic wait_beats(input int n);
    int guard;
    guard = 0;
    while ((out_q.size() - base) < n && guard < 200) begin
      @(negedge aclk);
      guard = guard + 1;
    end
    chk("wait_beats", 32'(out_q.size() - base >= n), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 32'(initiator_tvalid), 32'd0);
    chk("rst_tready", 32'(target_tready), 32'd0);
`ifdef FRAMER_FRAME_CNT_EN
    chk("rst_count", 32'(frame_count), 32'd0);
`endif
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("idle_tvalid", 32'(initiator_tvalid), 32'd0);
    @(posedge aclk);
    #1;

    // Plain frame.
    base = out_q.size();
    fr_q = {8'h01, 8'h02, 8'h03};
    send_frame();
    exp_q = {8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E};
    check_out("basic", 1'b1);

    // Back-to-back frames, no gap cycles.
    base = out_q.size();
    fr_q = {8'h04, 8'h05};
    send_frame();
    fr_q = {8'h06};
    send_frame();
    exp_q = {8'h7D, 8'h04, 8'h05, 8'h7E, 8'h7D, 8'h06, 8'h7E};
    check_out("b2b", 1'b1);

    // All three special bytes plus a normal one.
    base = out_q.size();
    fr_q = {8'h7D, 8'h7E, 8'h7F, 8'h00};
    send_frame();
    exp_q = {8'h7D, 8'h7F, 8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7F, 8'h00, 8'h7E};
    check_out("escape", 1'b1);

    // Single special byte with tlast.
    base = out_q.size();
    fr_q = {8'h7E};
    send_frame();
    exp_q = {8'h7D, 8'h7F, 8'h7E, 8'h7E};
    check_out("single", 1'b1);

    // Upstream gap mid-frame emits no filler.
    base = out_q.size();
    send_byte(8'h30, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    send_byte(8'h31, 1'b1);
    exp_q = {8'h7D, 8'h30, 8'h31, 8'h7E};
    check_out("us_stall", 1'b0);

    // Downstream ready toggling every cycle.
    toggle_mode = 1'b1;
    base = out_q.size();
    fr_q = {8'h10, 8'h11, 8'h12};
    send_frame();
    exp_q = {8'h7D, 8'h10, 8'h11, 8'h12, 8'h7E};
    check_out("bp", 1'b0);
    toggle_mode = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("bp_stable", 32'(stall_viol), 32'd0);

    // Reset mid-frame abandons the partial frame.
    base = out_q.size();
    send_byte(8'h10, 1'b0);
    wait_beats(2);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("midrst_tvalid", 32'(initiator_tvalid), 32'd0);
    chk("midrst_tready", 32'(target_tready), 32'd0);
`ifdef FRAMER_FRAME_CNT_EN
    chk("midrst_count", 32'(frame_count), 32'd0);
`endif
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    base = out_q.size();
    send_byte(8'h20, 1'b1);
    exp_q = {8'h7D, 8'h20, 8'h7E};
    check_out("post_rst", 1'b0);

`ifdef FRAMER_FRAME_CNT_EN
    // Frame counter over three back-to-back frames.
    begin
      int cbase;
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      @(negedge aclk);
      chk("cnt_reset", 32'(frame_count), 32'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      base  = out_q.size();
      cbase = cnt_q.size();
      fr_q = {8'h01};
      send_frame();
      fr_q = {8'h02};
      send_frame();
      fr_q = {8'h03};
      send_frame();
      exp_q = {8'h7D, 8'h01, 8'h7E, 8'h7D, 8'h02, 8'h7E, 8'h7D, 8'h03, 8'h7E};
      check_out("cnt_frames", 1'b1);
      chk("cnt_stops", 32'(cnt_q.size() - cbase), 32'd3);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cnt_before_stop%0d", i),
            32'((cbase + i < cnt_q.size()) ? cnt_q[cbase + i] : 16'hxxxx), 32'(i));
      end
      chk("cnt_final", 32'(frame_count), 32'd3);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
